// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard stall controller.
// State encodings, opcode constants and the rt-usage decode helper.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_detect.sv
// Load-use hazard detection between the ID instruction and an EXE load.
// Purely combinational.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] ID_Inst,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWr,
  input  logic [4:0]  EXE_Rw,
  output logic        lu_hit
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_bits;

  assign op = ID_Inst[31:26];
  assign rs = ID_Inst[25:21];
  assign rt = ID_Inst[20:16];
  assign unused_bits = ^ID_Inst[15:0];

  assign lu_hit = EXE_MemtoReg & EXE_RegWr & (EXE_Rw != 5'd0) &
                  ((EXE_Rw == rs) | (uses_rt(op) & (EXE_Rw == rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble/flush controller for the PC, IF/ID and ID/EXE registers.
// Optional STALL_PERF_CNT_EN adds stall_cycles and flush_events counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] ID_Inst,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWr,
  input  logic [4:0]  EXE_Rw,
  input  logic        mem_busy,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_exe_stall,
  output logic        id_exe_bubble,
  output logic        if_id_flush,
  output logic [1:0]  hazard_state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t        state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             lu_hit;
  logic             pc_s, ifid_s, idex_s, bub, fl;
  logic             br_acc;

  hazard_detect u_detect (
    .ID_Inst      (ID_Inst),
    .EXE_MemtoReg (EXE_MemtoReg),
    .EXE_RegWr    (EXE_RegWr),
    .EXE_Rw       (EXE_Rw),
    .lu_hit       (lu_hit)
  );

  always_comb begin
    pc_s    = 1'b0;
    ifid_s  = 1'b0;
    idex_s  = 1'b0;
    bub     = 1'b0;
    fl      = 1'b0;
    br_acc  = 1'b0;
    nxt     = state;
    nxt_cnt = cnt;
    if (mem_busy) begin
      // memory hold overrides everything in every state
      pc_s    = 1'b1;
      ifid_s  = 1'b1;
      idex_s  = 1'b1;
      nxt     = HZ_MEM_WAIT;
      nxt_cnt = '0;
    end else begin
      unique case (state)
        HZ_IDLE, HZ_MEM_WAIT, HZ_LU_STALL: begin
          nxt = HZ_IDLE;
          if (branch_taken) begin
            fl     = 1'b1;
            bub    = 1'b1;
            br_acc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              nxt     = HZ_FLUSH;
              nxt_cnt = FL_LOAD;
            end
          end else if (state == HZ_LU_STALL) begin
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            bub     = 1'b1;
            nxt_cnt = cnt - 1'b1;
            if (cnt > 1) nxt = HZ_LU_STALL;
          end else if (lu_hit) begin
            pc_s   = 1'b1;
            ifid_s = 1'b1;
            bub    = 1'b1;
            if (LU_CYCLES > 1) begin
              nxt     = HZ_LU_STALL;
              nxt_cnt = LU_LOAD;
            end
          end
        end
        HZ_FLUSH: begin
          fl      = 1'b1;
          bub     = 1'b1;
          nxt_cnt = cnt - 1'b1;
          if (cnt <= 1) nxt = HZ_IDLE;
        end
        default: nxt = HZ_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
    end
  end

  assign pc_stall      = pc_s & ~reset;
  assign if_id_stall   = ifid_s & ~reset;
  assign id_exe_stall  = idex_s & ~reset;
  assign id_exe_bubble = bub & ~reset;
  assign if_id_flush   = fl & ~reset;
  assign hazard_state  = reset ? 2'd0 : state;

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (br_acc && flush_events != '1)
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: default build plus LU_CYCLES=3/FLUSH_CYCLES=2.
// Table vectors feed an expected-output queue checked each cycle.
module tb_hazard_stall_ctrl;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        mtr;
    logic        rwr;
    logic [4:0]  rw;
    logic        busy;
    logic        br;
    logic [6:0]  e0;
    logic [6:0]  e3;
  } vec_t;

  typedef struct {
    logic [6:0] e0;
    logic [6:0] e3;
    int         id;
  } exp_t;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h00A5_3020;
  localparam logic [31:0] ADDI = 32'h2025_0000;
  localparam logic [31:0] RS0  = 32'h0000_3020;
  localparam logic [31:0] SW   = 32'hAC25_0000;
  localparam logic [31:0] LW   = 32'h8C25_0000;
  localparam logic [31:0] BEQ  = 32'h1025_0000;
  localparam logic [6:0]  Z    = 7'd0;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] ID_Inst;
  logic        EXE_MemtoReg, EXE_RegWr;
  logic [4:0]  EXE_Rw;
  logic        mem_busy, branch_taken;
  logic        pc0, ifid0, idex0, bub0, fl0;
  logic        pc3, ifid3, idex3, bub3, fl3;
  logic [1:0]  hs0, hs3;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] sc0, unused_sc3;
  logic [15:0] fe0, unused_fe3;
`endif

  int checks = 0;
  int failures = 0;
  int sc_model = 0;
  int fe_model = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 CLK = ~CLK;

  hazard_stall_ctrl u0 (
    .CLK(CLK), .reset(reset), .ID_Inst(ID_Inst),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWr(EXE_RegWr),
    .EXE_Rw(EXE_Rw), .mem_busy(mem_busy),
    .branch_taken(branch_taken),
    .pc_stall(pc0), .if_id_stall(ifid0),
    .id_exe_stall(idex0), .id_exe_bubble(bub0),
    .if_id_flush(fl0), .hazard_state(hs0)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(sc0), .flush_events(fe0)
`endif
  );

  hazard_stall_ctrl #(.LU_CYCLES(3), .FLUSH_CYCLES(2)) u3 (
    .CLK(CLK), .reset(reset), .ID_Inst(ID_Inst),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWr(EXE_RegWr),
    .EXE_Rw(EXE_Rw), .mem_busy(mem_busy),
    .branch_taken(branch_taken),
    .pc_stall(pc3), .if_id_stall(ifid3),
    .id_exe_stall(idex3), .id_exe_bubble(bub3),
    .if_id_flush(fl3), .hazard_state(hs3)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(unused_sc3), .flush_events(unused_fe3)
`endif
  );

  function automatic logic [6:0] lu(input logic [1:0] h);
    return {5'b11010, h};
  endfunction
  function automatic logic [6:0] st(input logic [1:0] h);
    return {5'b11100, h};
  endfunction
  function automatic logic [6:0] fb(input logic [1:0] h);
    return {5'b00011, h};
  endfunction
  function automatic logic [6:0] mw();
    return {5'b00000, 2'd2};
  endfunction

  function automatic vec_t v(
    input logic rst, input logic [31:0] inst,
    input logic mtr, input logic rwr, input logic [4:0] rw,
    input logic busy, input logic br,
    input logic [6:0] e0, input logic [6:0] e3);
    vec_t r;
    r.rst = rst; r.inst = inst; r.mtr = mtr; r.rwr = rwr;
    r.rw = rw; r.busy = busy; r.br = br; r.e0 = e0; r.e3 = e3;
    return r;
  endfunction

  task automatic step(input vec_t x, input int id);
    exp_t e, g;
    logic [6:0] a0, a3;
    reset        = x.rst;
    ID_Inst      = x.inst;
    EXE_MemtoReg = x.mtr;
    EXE_RegWr    = x.rwr;
    EXE_Rw       = x.rw;
    mem_busy     = x.busy;
    branch_taken = x.br;
    e.e0 = x.e0; e.e3 = x.e3; e.id = id;
    sb.push_back(e);
    if (x.rst) begin
      sc_model = 0;
      fe_model = 0;
    end else begin
      if (x.e0[6]) sc_model++;
      if (x.e0[2] && x.e0[1:0] != 2'd3) fe_model++;
    end
    @(negedge CLK);
    g  = sb.pop_front();
    a0 = {pc0, ifid0, idex0, bub0, fl0, hs0};
    a3 = {pc3, ifid3, idex3, bub3, fl3, hs3};
    checks++;
    if (a0 !== g.e0) begin
      failures++;
      $display("FAIL vec%0d dut_default got=%b want=%b", g.id, a0, g.e0);
    end
    checks++;
    if (a3 !== g.e3) begin
      failures++;
      $display("FAIL vec%0d dut_lu3 got=%b want=%b", g.id, a3, g.e3);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(v(1, ADD,  1, 1, 5, 1, 0, Z,     Z));
    vecs.push_back(v(1, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, ADD,  1, 1, 5, 0, 0, lu(0), lu(0)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     lu(1)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     lu(1)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, ADDI, 1, 1, 5, 0, 0, Z,     Z));
    vecs.push_back(v(0, RS0,  1, 1, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, ADD,  1, 0, 5, 0, 0, Z,     Z));
    vecs.push_back(v(0, SW,   1, 1, 5, 0, 0, lu(0), lu(0)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     lu(1)));
    vecs.push_back(v(1, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, LW,   1, 1, 5, 0, 0, Z,     Z));
    vecs.push_back(v(0, BEQ,  1, 1, 5, 0, 0, lu(0), lu(0)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 1, fb(0), fb(1)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     fb(3)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, ADD,  1, 1, 5, 0, 1, fb(0), fb(0)));
    vecs.push_back(v(0, ADD,  1, 1, 5, 1, 1, st(0), st(3)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 1, 0, st(2), st(2)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 1, 0, st(2), st(2)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 1, 0, st(2), st(2)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, mw(),  mw()));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(v(0, NOP,  0, 0, 0, 1, 0, st(0), st(0)));
    vecs.push_back(v(0, ADD,  1, 1, 5, 0, 0, lu(2), lu(2)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 1, 0, st(0), st(1)));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, mw(),  mw()));
    vecs.push_back(v(0, NOP,  0, 0, 0, 0, 0, Z,     Z));

    #1;
    foreach (vecs[i]) step(vecs[i], i);

    // load-use held across cycles: default re-triggers, LU=3 keeps counting
    step(v(0, ADD, 1, 1, 5, 0, 0, lu(0), lu(0)), 100);
    step(v(0, ADD, 1, 1, 5, 0, 0, lu(0), lu(1)), 101);
    step(v(0, NOP, 0, 0, 0, 0, 0, Z,     lu(1)), 102);
    step(v(0, NOP, 0, 0, 0, 0, 0, Z,     Z),     103);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

`ifdef STALL_PERF_CNT_EN
    checks++;
    if (sc0 !== 32'(sc_model)) begin
      failures++;
      $display("FAIL stall_cycles got=%0d want=%0d", sc0, sc_model);
    end
    checks++;
    if (fe0 !== 16'(fe_model)) begin
      failures++;
      $display("FAIL flush_events got=%0d want=%0d", fe0, fe_model);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller that generates the stall, bubble and flush controls consumed by the PC register, IF/ID register and ID/EXE register.
- Detects load-use hazards between the instruction in ID and a load in EXE.
- Holds the whole front pipeline while data memory is busy.
- Flushes wrong-path instructions after a taken branch resolved in EXE.
- Mealy FSM with a cycle counter; sits beside the ID stage.

Parameters:
LU_CYCLES, 1, stall cycles inserted per load-use hazard (1..15)
FLUSH_CYCLES, 1, cycles of flush/bubble after a taken branch (1..15)
CNT_W, 4, width of internal cycle counter

Ports:
CLK  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
ID_Inst  input  32  instruction in ID stage
EXE_MemtoReg  input  1  EXE instruction is a load
EXE_RegWr  input  1  EXE instruction writes register file
EXE_Rw  input  5  EXE destination register
mem_busy  input  1  data memory not ready; MEM stage must hold
branch_taken  input  1  EXE-stage branch resolved taken
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
id_exe_stall  output  1  hold ID/EXE register
id_exe_bubble  output  1  load NOP (all control fields 0) into ID/EXE
if_id_flush  output  1  load NOP into IF/ID
hazard_state  output  2  current FSM state, for debug

Behaviour:
- Decoding:
  - rs = ID_Inst[25:21], rt = ID_Inst[20:16], op = ID_Inst[31:26].
  - uses_rt = 1 when op is 6'h00, 6'h2B, 6'h04 or 6'h05.
- lu_hit = EXE_MemtoReg & EXE_RegWr & (EXE_Rw != 0) & ((EXE_Rw == rs) | (uses_rt & EXE_Rw == rt)).
- States: IDLE=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2, FLUSH=2'd3. Counter cnt is CNT_W bits.
- Event priority in any state: mem_busy > branch_taken > lu_hit.
- IDLE:
  - mem_busy: assert pc_stall, if_id_stall, id_exe_stall this cycle; next state MEM_WAIT.
  - else branch_taken: assert if_id_flush, id_exe_bubble this cycle. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1; else stay IDLE.
  - else lu_hit: assert pc_stall, if_id_stall, id_exe_bubble this cycle. If LU_CYCLES > 1, go to LU_STALL with cnt = LU_CYCLES-1; else stay IDLE.
  - otherwise all outputs 0.
- LU_STALL:
  - Outputs as for lu_hit; decrement cnt.
  - cnt == 1: return to IDLE next cycle.
  - mem_busy preempts: go to MEM_WAIT; the LU count is discarded.
  - branch_taken preempts: go to FLUSH (counter loaded as in IDLE). The flush wins over the stall this cycle: if_id_flush=1, pc_stall=0.
- MEM_WAIT:
  - pc_stall = if_id_stall = id_exe_stall = 1 for as long as mem_busy = 1.
  - On the first cycle with mem_busy = 0: outputs are evaluated as in IDLE in that same cycle; state returns to IDLE (or FLUSH/LU_STALL per IDLE rules).
- FLUSH: if_id_flush = id_exe_bubble = 1; decrement cnt; return to IDLE when cnt == 1. mem_busy preempts to MEM_WAIT.
- id_exe_stall and id_exe_bubble are never both 1. When mem_busy = 1, stall wins.
- Latency: all outputs are combinational from state and inputs (zero-cycle). Only state and cnt are registered.
- Reset: synchronous; reset = 1 at a rising edge sets state = IDLE, cnt = 0. Output values while reset is held: all outputs 0, hazard_state = 0. Reset mid-stall aborts immediately.
- EXE_Rw = 0 never causes a hazard.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds output stall_cycles [31:0], counting rising edges where pc_stall = 1. Saturates at 32'hFFFFFFFF; cleared by reset.
- Also adds flush_events [15:0], incremented once per taken branch accepted in IDLE/LU_STALL. Saturates at 16'hFFFF; cleared by reset.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

Decomposition:
Shared package/header holds:
- state encodings HZ_IDLE, HZ_LU_STALL, HZ_MEM_WAIT, HZ_FLUSH;
- opcode constants OP_RTYPE=6'h00, OP_SW=6'h2B, OP_BEQ=6'h04, OP_BNE=6'h05.

One natural sub-module, hazard_detect: purely combinational computation of lu_hit from ID_Inst, EXE_MemtoReg, EXE_RegWr and EXE_Rw. The FSM and counter stay in the top module.

Test Plan:
- Load-use: EXE_MemtoReg=1, EXE_RegWr=1, EXE_Rw=5, ID_Inst = add with rs=5 (32'h00A53020) -> exactly 1 cycle of pc_stall=if_id_stall=id_exe_bubble=1, then all 0. Repeat with ID_Inst = addi with rt=5 (uses_rt=0) -> no stall. Repeat with EXE_Rw=0 -> no stall.
- LU_CYCLES=3, same load-use stimulus -> stall/bubble high for 3 consecutive cycles; hazard_state sequence 0,1,1,0.
- mem_busy high for 4 cycles -> pc_stall/if_id_stall/id_exe_stall high for exactly those 4 cycles; id_exe_bubble stays 0; hazard_state = 2 from the 2nd cycle.
- branch_taken and lu_hit in the same cycle -> if_id_flush=1, id_exe_bubble=1, pc_stall=0. Add mem_busy=1 -> stalls only, no flush.
- Assert reset during LU_STALL (LU_CYCLES=3, 2nd cycle) -> next edge: hazard_state=0, all outputs 0; after reset deasserts, no residual stall.
- With STALL_PERF_CNT_EN: 3 load-use stalls of 1 cycle plus a 4-cycle mem_busy -> stall_cycles=7. Two taken branches -> flush_events=2.
